spi_slave_controller: RTL
=========================

SPI_SLAVE_CONTROLLER -- requirements
Module: spi_slave_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop stages on i_sclk, i_ss_n and i_mosi (legal values 2..3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port i_data_to_registers  input  32  register write data.
REQ-005 SHALL have port i_wr_controll_reg  input  1  control register write strobe, one clk long.
REQ-006 SHALL have port i_wr_data_reg  input  1  TX holding register write strobe; uses data bits [7:0].
REQ-007 SHALL have port i_read_status_reg  input  1  status read strobe; clears sticky flags.
REQ-008 SHALL have port o_controll_reg  output  32  control register contents.
REQ-009 SHALL have port o_status_reg  output  32  {24'b0, RXF, WCOL, OVR, TXE, UDR, BUSY, 2'b0}.
REQ-010 SHALL have port o_data_reg  output  32  {24'b0, last complete received byte}.
REQ-011 SHALL have port o_IRQ  output  1  interrupt request, active-high.
REQ-012 SHALL have port i_sclk  input  1  SPI clock from the master, asynchronous.
REQ-013 SHALL have port i_ss_n  input  1  slave select, active-low, asynchronous.
REQ-014 SHALL have port i_mosi  input  1  serial data from the master.
REQ-015 SHALL have port o_miso  output  1  serial data to the master.
REQ-016 SHALL have port o_miso_oe  output  1  MISO output enable; the pad tri-states when 0.

Function
REQ-017 SHALL use control bits [7] irq_en, [5] lsb_first (1 = LSB first), [3] CPOL, [2] CPHA; all other bits are stored and have no function.
REQ-018 SHALL synchronise i_sclk, i_ss_n and i_mosi through SYNC_STAGES flops and detect SCLK edges on the synchronised signal; clk SHALL be at least 8x the SCLK frequency.
REQ-019 SHALL use the sample edge = rising when CPOL==CPHA, else falling; the setup edge is the opposite edge.
REQ-020 SHALL implement FSM IDLE -> ACTIVE when the synchronised SS goes low; ACTIVE -> IDLE when it goes high; BUSY=1 and o_miso_oe=1 exactly while in ACTIVE.
REQ-021 SHALL, in ACTIVE on each sample edge, shift the synchronised MOSI into rx_shr (MSB first: shift left and insert at bit 0; LSB first: shift right and insert at bit 7), and increment the 3-bit bit counter.
REQ-022 SHALL, on the 8th sample edge of a byte: copy the completed byte into the data register one clk later, set RXF in that same cycle, and wrap the bit counter to 0; the session continues while SS stays low.
REQ-023 SHALL set OVR in the cycle the data register is written if RXF is already 1; the new byte overwrites the data register.
REQ-024 SHALL load tx_shr at each byte start from the TX holding register and set TXE=1. Byte start is: CPHA=0 -> SS assertion and the clk after the 8th sample edge; CPHA=1 -> the first setup edge of the byte.
REQ-025 SHALL, at a byte start with TXE=1, load 0x00 and set UDR.
REQ-026 SHALL, on a byte-start cycle coinciding with i_wr_data_reg while TXE=1, load the written byte directly, leave TXE=1 and not set UDR.
REQ-027 SHALL shift tx_shr on setup edges that are not a byte start; with CPHA=0 the setup edge immediately after the 8th sample edge does not shift.
REQ-028 SHALL drive o_miso with tx_shr[7] (MSB first) or tx_shr[0] (LSB first).
REQ-029 SHALL, on i_wr_data_reg, write [7:0] to the holding register and clear TXE; a write while TXE=0 overwrites the holding register.
REQ-030 SHALL, on i_wr_controll_reg while BUSY=1, ignore the write and set WCOL; while BUSY=0 the write takes effect.
REQ-031 SHALL, when SS deasserts mid-byte, discard the partial byte (no RXF, no data register update), clear the bit counter, keep the holding register and TXE, and drop o_miso_oe to 0 in the same cycle BUSY falls.
REQ-032 SHALL clear RXF, WCOL, OVR and UDR on i_read_status_reg; a set event in the same cycle wins.
REQ-033 SHALL drive o_IRQ = irq_en & (RXF | OVR | UDR), combinational from flops.

Reset
REQ-034 SHALL, while RST=1: set the FSM to IDLE; zero the control reg, data reg, rx_shr, tx_shr, holding reg and bit counter; set o_status_reg=0x10 (TXE only); drive o_IRQ=0, o_miso_oe=0, o_miso=0; flush the synchronisers to the idle SCLK level = 0, SS_n = 1.
REQ-035 SHALL, when reset is asserted mid-transfer, abort the transfer with no flag set; after release the block ignores SCLK edges until SS is deasserted and reasserted.

Verification
REQ-036 SHALL verify mode 0, MSB first, holding=0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_data_reg=0x3C; RXF=1; o_IRQ=1 when irq_en=1; status read -> RXF=0.
REQ-037 SHALL verify mode 3, LSB first, holding=0x81, master sends 0x0F -> master receives 0x81; o_data_reg=0x0F.
REQ-038 SHALL verify 2-byte session with no TX write and no status read -> 2nd byte: MISO all 0, UDR=1, OVR=1, o_data_reg = 2nd byte.
REQ-039 SHALL verify SS raised after 5 bits -> RXF=0, o_data_reg unchanged, BUSY=0, o_miso_oe=0.
REQ-040 SHALL verify control write 0x8C while BUSY -> o_controll_reg unchanged, WCOL=1; status read after SS high -> WCOL=0.
REQ-041 SHALL verify RST pulse during bit 4 -> status=0x10, no RXF; next full session with SS toggled completes normally.

Source files
------------

// File: rtl/spi_slave_controller.sv
// SPI slave with control/status/data registers on the system side.
// SPI pins are synchronised into clk and all serial behaviour keys off detected SCLK edges.
module spi_slave_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] i_data_to_registers,
    input  logic        i_wr_controll_reg,
    input  logic        i_wr_data_reg,
    input  logic        i_read_status_reg,
    output logic [31:0] o_controll_reg,
    output logic [31:0] o_status_reg,
    output logic [31:0] o_data_reg,
    output logic        o_IRQ,
    input  logic        i_sclk,
    input  logic        i_ss_n,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, sync_vld_q, sync_vld_d;
    logic        sclk_prev_q, sclk_prev_d, armed_q, armed_d, done_q, done_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [7:0]  data_q, data_d, rx_shr_q, rx_shr_d, tx_shr_q, tx_shr_d, hold_q, hold_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        rxf_q, rxf_d, wcol_q, wcol_d, ovr_q, ovr_d, txe_q, txe_d, udr_q, udr_d;

    logic sclk_s, ss_s, mosi_s, irq_en, lsb_first, cpol, cpha, busy;
    logic sclk_rise, sclk_fall, sample_edge, setup_edge, byte_start, tx_shift;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign irq_en    = ctrl_q[7];
    assign lsb_first = ctrl_q[5];
    assign cpol      = ctrl_q[3];
    assign cpha      = ctrl_q[2];
    assign busy      = (state_q == ACTIVE);

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = (cpol == cpha) ? sclk_rise : sclk_fall;
    assign setup_edge  = (cpol == cpha) ? sclk_fall : sclk_rise;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], i_ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
        sync_vld_d  = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        // Only arm once a genuine (post-flush) SS-high has been seen, so a
        // reset in the middle of a transfer does not re-enter ACTIVE.
        armed_d     = armed_q | (sync_vld_q[SYNC_STAGES-1] & ss_s);
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        rx_shr_d    = rx_shr_q;
        tx_shr_d    = tx_shr_q;
        hold_d      = hold_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = 1'b0;
        rxf_d       = rxf_q & ~i_read_status_reg;
        wcol_d      = wcol_q & ~i_read_status_reg;
        ovr_d       = ovr_q & ~i_read_status_reg;
        udr_d       = udr_q & ~i_read_status_reg;
        txe_d       = txe_q;
        byte_start  = 1'b0;
        tx_shift    = 1'b0;

        if (i_wr_controll_reg) begin
            if (busy) wcol_d = 1'b1;
            else      ctrl_d = i_data_to_registers;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (armed_q && !ss_s) begin
                    state_d    = ACTIVE;
                    byte_start = !cpha;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else begin
                    if (sample_edge) begin
                        rx_shr_d  = lsb_first ? {mosi_s, rx_shr_q[7:1]} : {rx_shr_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        done_d    = (bit_cnt_q == 3'd7);
                    end
                    // Setup edge with bit_cnt==0 is either the CPHA=1 byte start or
                    // the CPHA=0 trailing edge after byte completion; neither shifts.
                    if (setup_edge) begin
                        if (bit_cnt_q == 3'd0) byte_start = cpha;
                        else                   tx_shift   = 1'b1;
                    end
                    if (done_q && !cpha) byte_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_start) begin
            if (!txe_q) begin
                tx_shr_d = hold_q;
                txe_d    = 1'b1;
            end else if (i_wr_data_reg) begin
                tx_shr_d = i_data_to_registers[7:0];
            end else begin
                tx_shr_d = 8'h00;
                udr_d    = 1'b1;
            end
        end else if (tx_shift) begin
            tx_shr_d = lsb_first ? {1'b0, tx_shr_q[7:1]} : {tx_shr_q[6:0], 1'b0};
        end

        if (i_wr_data_reg) begin
            hold_d = i_data_to_registers[7:0];
            if (!(byte_start && txe_q)) txe_d = 1'b0;
        end

        if (done_q) begin
            data_d = rx_shr_q;
            rxf_d  = 1'b1;
            if (rxf_q) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sync_vld_q  <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
            rx_shr_q    <= '0;
            tx_shr_q    <= '0;
            hold_q      <= '0;
            bit_cnt_q   <= '0;
            rxf_q       <= 1'b0;
            wcol_q      <= 1'b0;
            ovr_q       <= 1'b0;
            txe_q       <= 1'b1;
            udr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sync_vld_q  <= sync_vld_d;
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            rx_shr_q    <= rx_shr_d;
            tx_shr_q    <= tx_shr_d;
            hold_q      <= hold_d;
            bit_cnt_q   <= bit_cnt_d;
            rxf_q       <= rxf_d;
            wcol_q      <= wcol_d;
            ovr_q       <= ovr_d;
            txe_q       <= txe_d;
            udr_q       <= udr_d;
        end
    end

    assign o_controll_reg = ctrl_q;
    assign o_status_reg   = {24'b0, rxf_q, wcol_q, ovr_q, txe_q, udr_q, busy, 2'b00};
    assign o_data_reg     = {24'b0, data_q};
    assign o_IRQ          = irq_en & (rxf_q | ovr_q | udr_q);
    assign o_miso         = lsb_first ? tx_shr_q[0] : tx_shr_q[7];
    assign o_miso_oe      = busy;

endmodule
